wb_bram_ctrl: RTL and testbench
===============================

// Module: wb_bram_ctrl
// PURPOSE
//  Wishbone classic slave that fronts the user-project data BRAM (single-port, byte-write, registered read).
//  Sits directly upstream of the BRAM: decodes the user address window and inserts DELAYS wait states
//  (emulating slow memory). Drives EN/WE/A/Di into the BRAM, captures its registered Do, and returns
//  ack/data to the Caravel management core.
// PARAMETERS
//  BASE_TOP  8'h38  adr[31:24] value selecting this slave
//  N         13     BRAM word-address width (2**N 32-bit words)
//  DELAYS    10     wait cycles inserted before the BRAM access (0..255)
// PORTS
//  wb_clk_i     in   1   clock; also clocks the BRAM
//  wb_rst_n     in   1   asynchronous active-low reset
//  wbs_cyc_i    in   1   bus cycle valid
//  wbs_stb_i    in   1   strobe
//  wbs_we_i     in   1   1=write, 0=read
//  wbs_sel_i    in   4   byte lane enables
//  wbs_adr_i    in   32  byte address
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   one-cycle transfer acknowledge
//  wbs_err_o    out  1   one-cycle error (see CONFIGURATION)
//  wbs_dat_o    out  32  read data, valid while wbs_ack_o=1
//  bram_en_o    out  1   BRAM enable
//  bram_we_o    out  4   BRAM byte write enables
//  bram_a_o     out  32  BRAM word address {zeros, adr[N+1:2]}
//  bram_di_o    out  32  BRAM write data
//  bram_do_i    in   32  BRAM registered read data (zero when not enabled)
//  busy_o       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, counter=0, all outputs 0, latched request cleared. Reset mid-transaction aborts with no ack.
//  - req = cyc & stb & (adr[31:24]==BASE_TOP). Accepted only in IDLE; adr/dat/sel/we latched on accept.
//  - States: IDLE -> WAIT (cnt=DELAYS; skipped if DELAYS=0) -> WR or RD.
//    WR: bram_en_o=1, bram_we_o=sel, one cycle -> ACK.
//    RD: bram_en_o=1, bram_we_o=0, one cycle -> RESP. RESP: wbs_dat_o<=bram_do_i -> ACK.
//    ACK: wbs_ack_o=1 for exactly one cycle -> IDLE.
//  - Latency (accept cycle = 0): write ack at DELAYS+2, read ack at DELAYS+3.
//  - BRAM ports are decoded from the state register and latched request only; no wbs_* -> bram_* combinational path.
//    bram_a_o/bram_di_o hold latched values during WR/RD, and are 0 otherwise.
//  - wbs_dat_o holds its last value outside ACK; wbs_sel_i=0 write still acks, no bytes change.
//  - cyc_i low during WAIT: go to IDLE, no BRAM access, no ack. Once in WR/RD/RESP/ACK, the sequence completes;
//    wbs_ack_o is gated with wbs_cyc_i.
//  - No re-accept in the ACK cycle; a request held in the cycle after ack starts a new transaction.
//  - Out-of-window requests are ignored entirely: no ack, no err, no BRAM activity.
//  - WAIT counter is 8-bit, decrements to 0, never wraps.
// CONFIGURATION
//  WB_BRAM_RANGE_ERR_EN defined: an in-window request with adr[23:N+2]!=0 goes IDLE->ERR.
//    In ERR, wbs_err_o=1 for one cycle (cycle 1) and the BRAM is never enabled.
//  Not defined: wbs_err_o tied 0; upper bits are ignored and the access aliases onto adr[N+1:2].
// TESTING
//  1. DELAYS=10, write 0xDEADBEEF sel=F @0x3800_0010 -> cycle 11 bram_en=1 we=F a=4 di=DEADBEEF; ack cycle 12.
//     Read-back -> ack cycle 13, dat=0xDEADBEEF.
//  2. Word 0x11223344, write sel=4'b0010 dat=0x0000AB00 -> read returns 0x1122AB44.
//  3. DELAYS=0: write ack at cycle 2, read ack at cycle 3; back-to-back requests each get exactly one ack.
//  4. adr=0x3000_0000 cyc/stb held 20 cycles -> no ack/err, bram_en_o stays 0, busy_o=0.
//  5. Drop cyc at cycle 5 (in WAIT) -> IDLE, no en/ack; assert reset in WAIT -> outputs 0 at once;
//     the next request completes normally.
//  6. adr=0x3810_0000 read: with macro -> err at cycle 1, no bram_en; without -> reads word 0, ack at DELAYS+3.

Source files
------------

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave in front of the single-port byte-write data BRAM, with DELAYS wait states per access.
// Optional macro WB_BRAM_RANGE_ERR_EN: error response for in-window addresses beyond the BRAM depth.
//
// state  | meaning
// IDLE   | waiting for an in-window request
// WAIT   | counting down the emulated memory delay
// WR     | BRAM write cycle (en=1, we=sel)
// RD     | BRAM read cycle (en=1, we=0)
// RESP   | BRAM registered data available, captured into wbs_dat_o
// ACK    | one-cycle acknowledge
// ERR    | one-cycle error (range check build only)
module wb_bram_ctrl #(
  parameter logic [7:0] BASE_TOP = 8'h38,
  parameter int         N        = 13,
  parameter int         DELAYS   = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_a_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i,
  output logic        busy_o
);

  localparam logic [7:0] DLY = 8'(DELAYS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WR, S_RD, S_RESP, S_ACK, S_ERR} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic          accept;
  logic          req, range_bad, access;
  logic [N-1:0]  adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          unused_adr;

  assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_TOP);

`ifdef WB_BRAM_RANGE_ERR_EN
  assign range_bad = |wbs_adr_i[23:N+2];
`else
  assign range_bad = 1'b0;
`endif

  // Byte-offset bits never matter; upper window bits only matter with the range check.
  assign unused_adr = ^{wbs_adr_i[23:N+2], wbs_adr_i[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (range_bad)
            state_nxt = S_ERR;
          else if (DELAYS == 0)
            state_nxt = wbs_we_i ? S_WR : S_RD;
          else begin
            state_nxt = S_WAIT;
            cnt_nxt   = DLY;
          end
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
          if (cnt <= 8'd1) state_nxt = we_q ? S_WR : S_RD;
        end
      end
      S_WR:    state_nxt = S_ACK;
      S_RD:    state_nxt = S_RESP;
      S_RESP:  state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      adr_q     <= '0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
      we_q      <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        adr_q <= wbs_adr_i[N+1:2];
        dat_q <= wbs_dat_i;
        sel_q <= wbs_sel_i;
        we_q  <= wbs_we_i;
      end
      if (state == S_RESP) wbs_dat_o <= bram_do_i;
    end
  end

  // BRAM side is decoded purely from registered state so no bus input reaches it combinationally.
  assign access    = (state == S_WR) || (state == S_RD);
  assign bram_en_o = access;
  assign bram_we_o = (state == S_WR) ? sel_q : 4'd0;
  assign bram_a_o  = access ? {{(32-N){1'b0}}, adr_q} : 32'd0;
  assign bram_di_o = access ? dat_q : 32'd0;

  assign wbs_ack_o = (state == S_ACK) & wbs_cyc_i;
`ifdef WB_BRAM_RANGE_ERR_EN
  assign wbs_err_o = (state == S_ERR);
`else
  assign wbs_err_o = 1'b0;
`endif
  assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: one instance with DELAYS=10, one with DELAYS=0, each backed by a BRAM model.
// Cycle 0 is the cycle a request is first driven; latencies are counted in clock edges from there.
module tb_wb_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc;
  logic        stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic [1:0]  ack, err, en, busy;
  logic [31:0] dat_o [2];
  logic [3:0]  bwe   [2];
  logic [31:0] ba    [2];
  logic [31:0] bdi   [2];
  logic [31:0] bdo   [2];
  logic [31:0] mem   [2][0:8191];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_bram_ctrl #(.BASE_TOP(8'h38), .N(13), .DELAYS(10)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]),
    .wbs_dat_o(dat_o[0]), .bram_en_o(en[0]), .bram_we_o(bwe[0]), .bram_a_o(ba[0]),
    .bram_di_o(bdi[0]), .bram_do_i(bdo[0]), .busy_o(busy[0]));

  wb_bram_ctrl #(.BASE_TOP(8'h38), .N(13), .DELAYS(0)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]),
    .wbs_dat_o(dat_o[1]), .bram_en_o(en[1]), .bram_we_o(bwe[1]), .bram_a_o(ba[1]),
    .bram_di_o(bdi[1]), .bram_do_i(bdo[1]), .busy_o(busy[1]));

  // BRAM model: registered read of old contents, byte writes, zero output when not enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        bdo[d] <= 32'd0;
        for (int i = 0; i < 8192; i++) mem[d][i] <= 32'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (en[d]) begin
          bdo[d] <= mem[d][ba[d][12:0]];
          for (int b = 0; b < 4; b++)
            if (bwe[d][b]) mem[d][ba[d][12:0]][8*b +: 8] <= bdi[d][8*b +: 8];
        end else begin
          bdo[d] <= 32'd0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the bus idle; returns #1 after the edge following ack/err (slave back in IDLE).
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output int ack_cyc, output int err_cyc, output int en_cyc,
                      output logic [3:0] we_s, output logic [31:0] a_s, output logic [31:0] di_s,
                      output logic [31:0] rd);
    ack_cyc = -1; err_cyc = -1; en_cyc = -1;
    we_s = 4'hx; a_s = 32'hx; di_s = 32'hx; rd = 32'hx;
    cyc[d] = 1'b1; stb = 1'b1; we = w; adr = a; dat = wd; sel = s;
    for (int k = 1; k <= 60 && ack_cyc < 0 && err_cyc < 0; k++) begin
      @(posedge clk); #1;
      if (en[d] && en_cyc < 0) begin
        en_cyc = k; we_s = bwe[d]; a_s = ba[d]; di_s = bdi[d];
      end
      if (ack[d]) begin ack_cyc = k; rd = dat_o[d]; end
      if (err[d]) err_cyc = k;
    end
    cyc = 2'b00; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int ac, ec, nc;
    logic [3:0]  ws;
    logic [31:0] as, ds, rd;
    logic [6:0]  mask;
    logic        seen_ack, seen_err, seen_en, seen_busy;

    rst_n = 1'b0; cyc = 2'b00; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; dat = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack",  32'(ack),  32'd0);
    check_eq("rst_en",   32'(en),   32'd0);
    check_eq("rst_dat",  dat_o[0],  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read, DELAYS=10
    xfer(0, 1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t1_wr_ack_cyc", 32'(ac), 32'd12);
    check_eq("t1_wr_en_cyc",  32'(nc), 32'd11);
    check_eq("t1_wr_we",      32'(ws), 32'hF);
    check_eq("t1_wr_a",       as,      32'd4);
    check_eq("t1_wr_di",      ds,      32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h3800_0010, 32'd0, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t1_rd_ack_cyc", 32'(ac), 32'd13);
    check_eq("t1_rd_we",      32'(ws), 32'h0);
    check_eq("t1_rd_dat",     rd,      32'hDEAD_BEEF);

    // Byte-lane merge, data hold, and a sel=0 write
    xfer(0, 1'b1, 32'h3800_0040, 32'h1122_3344, 4'hF, ac, ec, nc, ws, as, ds, rd);
    xfer(0, 1'b1, 32'h3800_0040, 32'h0000_AB00, 4'b0010, ac, ec, nc, ws, as, ds, rd);
    check_eq("t2_wr_we", 32'(ws), 32'h2);
    xfer(0, 1'b0, 32'h3800_0040, 32'd0, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t2_rd_dat", rd, 32'h1122_AB44);
    check_eq("t2_dat_hold", dat_o[0], 32'h1122_AB44);
    xfer(0, 1'b1, 32'h3800_0040, 32'hFFFF_FFFF, 4'h0, ac, ec, nc, ws, as, ds, rd);
    check_eq("t2_sel0_ack", 32'(ac), 32'd12);
    xfer(0, 1'b0, 32'h3800_0040, 32'd0, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t2_sel0_dat", rd, 32'h1122_AB44);

    // DELAYS=0 instance
    xfer(1, 1'b1, 32'h3800_0008, 32'h55AA_55AA, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t3_wr_ack_cyc", 32'(ac), 32'd2);
    check_eq("t3_wr_a", as, 32'd2);
    xfer(1, 1'b0, 32'h3800_0008, 32'd0, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t3_rd_ack_cyc", 32'(ac), 32'd3);
    check_eq("t3_rd_dat", rd, 32'h55AA_55AA);
    cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_000C; dat = 32'd1; sel = 4'hF;
    mask = 7'd0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      mask[k] = ack[1];
    end
    cyc = 2'b00; stb = 1'b0;
    @(posedge clk); #1;
    check_eq("t3_b2b_mask", 32'(mask), 32'h24);

    // Out-of-window request held for 20 cycles
    seen_ack = 0; seen_err = 0; seen_en = 0; seen_busy = 0;
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      seen_ack |= ack[0]; seen_err |= err[0]; seen_en |= en[0]; seen_busy |= busy[0];
    end
    cyc = 2'b00; stb = 1'b0;
    @(posedge clk); #1;
    check_eq("t4_no_ack",  32'(seen_ack),  32'd0);
    check_eq("t4_no_err",  32'(seen_err),  32'd0);
    check_eq("t4_no_en",   32'(seen_en),   32'd0);
    check_eq("t4_no_busy", 32'(seen_busy), 32'd0);

    // Abort in WAIT by dropping cyc at cycle 5
    seen_ack = 0; seen_en = 0;
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0020; dat = 32'h1234_5678; sel = 4'hF;
    for (int k = 1; k <= 5; k++) begin @(posedge clk); #1; end
    check_eq("t5_busy_in_wait", 32'(busy[0]), 32'd1);
    cyc = 2'b00; stb = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_idle_after_drop", 32'(busy[0]), 32'd0);
    for (int k = 0; k < 15; k++) begin
      seen_ack |= ack[0]; seen_en |= en[0];
      @(posedge clk); #1;
    end
    check_eq("t5_drop_no_en",  32'(seen_en),  32'd0);
    check_eq("t5_drop_no_ack", 32'(seen_ack), 32'd0);
    xfer(0, 1'b0, 32'h3800_0020, 32'd0, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t5_drop_unwritten", rd, 32'd0);

    // Reset while in WAIT
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0030; dat = 32'h0BAD_F00D; sel = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", 32'(busy[0]), 32'd0);
    check_eq("t5_rst_en",   32'(en[0]),   32'd0);
    check_eq("t5_rst_ack",  32'(ack[0]),  32'd0);
    cyc = 2'b00; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b1, 32'h3800_0030, 32'h0BAD_F00D, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t5_post_wr_ack", 32'(ac), 32'd12);
    xfer(0, 1'b0, 32'h3800_0030, 32'd0, 4'hF, ac, ec, nc, ws, as, ds, rd);
    check_eq("t5_post_rd_ack", 32'(ac), 32'd13);
    check_eq("t5_post_rd_dat", rd, 32'h0BAD_F00D);

    // Upper window bits set
    xfer(0, 1'b1, 32'h3800_0000, 32'hCAFE_F00D, 4'hF, ac, ec, nc, ws, as, ds, rd);
    xfer(0, 1'b0, 32'h3810_0000, 32'd0, 4'hF, ac, ec, nc, ws, as, ds, rd);
`ifdef WB_BRAM_RANGE_ERR_EN
    check_eq("t6_err_cyc", 32'(ec), 32'd1);
    check_eq("t6_no_en",   32'(nc), 32'hFFFF_FFFF);
    check_eq("t6_no_ack",  32'(ac), 32'hFFFF_FFFF);
`else
    check_eq("t6_no_err",  32'(ec), 32'hFFFF_FFFF);
    check_eq("t6_ack_cyc", 32'(ac), 32'd13);
    check_eq("t6_alias",   rd,      32'hCAFE_F00D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
